// File: rtl/pulse_pair_gen.sv
// Programmable signal1/signal2 pulse-pair source for exercising CLK_Timer and the link timing path.
// A start emits reps pairs whose rising edges are delay cycles apart, separated by gap idle cycles.
module pulse_pair_gen #(
    parameter int CW     = 8,
    parameter int MAXREP = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width1,
    input  logic [CW-1:0] width2,
    input  logic [CW-1:0] gap,
    input  logic [3:0]    reps,
    output logic          signal1,
    output logic          signal2,
    output logic          busy,
    output logic          done
);
    localparam int TW = CW + 1;
    localparam logic [3:0] REP_MAX = 4'(MAXREP);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;
    state_t state, nstate;

    logic [CW-1:0] d_q, w1_q, w2_q, g_q;
    logic [CW-1:0] gc_q, ngc;
    logic [TW-1:0] t_q, nt;
    logic [3:0]    rem_q, nrem, rem_dec;
    logic          latch;

    function automatic logic [CW-1:0] nz(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    logic [3:0] reps_sat, reps_eff;
    assign reps_sat = (reps > REP_MAX) ? REP_MAX : reps;
    assign reps_eff = (reps_sat == 4'd0) ? 4'd1 : reps_sat;

    // In IDLE the live inputs feed the first RUN cycle's outputs; afterwards only latched copies.
    logic          idle;
    logic [CW-1:0] ed, ew1, ew2, eg;
    assign idle = (state == IDLE);
    assign ed   = idle ? delay      : d_q;
    assign ew1  = idle ? nz(width1) : w1_q;
    assign ew2  = idle ? nz(width2) : w2_q;
    assign eg   = idle ? nz(gap)    : g_q;

    logic [TW-1:0] s2_end, run_len;
    assign s2_end  = {1'b0, ed} + {1'b0, ew2};
    assign run_len = ({1'b0, ew1} > s2_end) ? {1'b0, ew1} : s2_end;
    assign rem_dec = rem_q - 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        nt     = t_q;
        ngc    = gc_q;
        nrem   = rem_q;
        latch  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch  = 1'b1;
                    nstate = RUN;
                    nt     = '0;
                    nrem   = reps_eff;
                end
            end
            RUN: begin
                if (t_q == run_len - TW'(1)) begin
                    nrem = rem_dec;
                    ngc  = '0;
                    nstate = (rem_dec != 4'd0) ? GAP : FIN;
                end else begin
                    nt = t_q + TW'(1);
                end
            end
            GAP: begin
                if (gc_q == eg - CW'(1)) begin
                    nstate = RUN;
                    nt     = '0;
                end else begin
                    ngc = gc_q + CW'(1);
                end
            end
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (abort) begin
            nstate = IDLE;
            latch  = 1'b0;
        end
    end

    // Outputs are registered from the next-state view so every pin comes straight off a flop.
    logic s1_n, s2_n, busy_n, done_n;
    assign s1_n   = (nstate == RUN) && (nt < {1'b0, ew1});
    assign s2_n   = (nstate == RUN) && (nt >= {1'b0, ed}) && (nt < s2_end);
    assign busy_n = (nstate == RUN) || (nstate == GAP);
    assign done_n = (nstate == FIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            g_q     <= '0;
            gc_q    <= '0;
            t_q     <= '0;
            rem_q   <= '0;
            signal1 <= 1'b0;
            signal2 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (latch) begin
                d_q  <= delay;
                w1_q <= nz(width1);
                w2_q <= nz(width2);
                g_q  <= nz(gap);
            end
            gc_q    <= ngc;
            t_q     <= nt;
            rem_q   <= nrem;
            signal1 <= s1_n;
            signal2 <= s2_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Bench for pulse_pair_gen: table-driven pulse-pair vectors checked cycle by cycle through a
// scoreboard queue, plus hand sequences for abort, busy-start, and async reset.
module tb_pulse_pair_gen;
    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] delay, width1, width2, gap;
    logic [3:0] reps;
    logic       signal1, signal2, busy, done;

    pulse_pair_gen #(.CW(8), .MAXREP(15)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .delay(delay), .width1(width1), .width2(width2), .gap(gap), .reps(reps),
        .signal1(signal1), .signal2(signal2), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d, w1, w2, g, r;
        int exp_busy;
        int exp_rise1;
        int exp_intv;
    } vec_t;

    vec_t       vt[7];
    logic [3:0] sb_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference waveform of {signal1, signal2, busy, done} for every cycle after the start edge.
    task automatic push_vec(input int d, input int w1, input int w2, input int g, input int r);
        int W1, W2, G, R, L;
        W1 = (w1 == 0) ? 1 : w1;
        W2 = (w2 == 0) ? 1 : w2;
        G  = (g == 0) ? 1 : g;
        R  = (r > 15) ? 15 : r;
        if (R == 0) R = 1;
        L  = (W1 > d + W2) ? W1 : d + W2;
        for (int rep = 0; rep < R; rep++) begin
            for (int t = 0; t < L; t++)
                sb_q.push_back({(t < W1), (t >= d && t < d + W2), 1'b1, 1'b0});
            if (rep < R - 1)
                for (int k = 0; k < G; k++) sb_q.push_back(4'b0010);
        end
        sb_q.push_back(4'b0001);
        sb_q.push_back(4'b0000);
        sb_q.push_back(4'b0000);
    endtask

    task automatic step_check(input string nm, output logic [3:0] o);
        o = {signal1, signal2, busy, done};
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty, got %b", nm, o);
        end else begin
            chk(nm, {28'd0, o}, {28'd0, sb_q.pop_front()});
        end
    endtask

    // Returns at the sample point of the first cycle after the start edge.
    task automatic start_pulse(input int d, input int w1, input int w2, input int g, input int r);
        @(negedge clk);
        delay  = 8'(d);
        width1 = 8'(w1);
        width2 = 8'(w2);
        gap    = 8'(g);
        reps   = 4'(r);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int         n, busy_cnt, rise1, first1, first2;
        logic       p1, p2;
        logic [3:0] o;
        push_vec(vt[i].d, vt[i].w1, vt[i].w2, vt[i].g, vt[i].r);
        n = sb_q.size();
        busy_cnt = 0; rise1 = 0; first1 = -1; first2 = -1; p1 = 1'b0; p2 = 1'b0;
        start_pulse(vt[i].d, vt[i].w1, vt[i].w2, vt[i].g, vt[i].r);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            step_check($sformatf("v%0d_c%0d", i, c), o);
            if (o[1]) busy_cnt++;
            if (o[3] && !p1) begin
                rise1++;
                if (first1 < 0) first1 = c;
            end
            if (o[2] && !p2 && first2 < 0) first2 = c;
            p1 = o[3];
            p2 = o[2];
        end
        chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vt[i].exp_busy);
        chk($sformatf("v%0d_s1_rises", i), rise1, vt[i].exp_rise1);
        chk($sformatf("v%0d_interval", i), first2 - first1, vt[i].exp_intv);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] o;
        //          d    w1  w2   g  r   busy rise intv
        vt[0] = '{  5,   5,  5,   0, 1,   10,  1,   5};
        vt[1] = '{  6,   8,  4,   0, 1,   10,  1,   6};
        vt[2] = '{  0,   0,  3,   2, 3,   13,  3,   0};
        vt[3] = '{  1,   3,  2,   0, 2,    7,  2,   1};
        vt[4] = '{  0,   4,  1,   3, 0,    4,  1,   0};
        vt[5] = '{  2,   1,  1,   1, 15,  59, 15,   2};
        vt[6] = '{255,   1, 255,  1, 1,  510,  1, 255};

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        delay = '0; width1 = '0; width2 = '0; gap = '0; reps = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {28'd0, signal1, signal2, busy, done}, 32'd0);
        reset = 1'b1;

        // Idle after reset release: nothing moves without a start.
        repeat (20) sb_q.push_back(4'b0000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            step_check($sformatf("idle_c%0d", c), o);
        end

        for (int i = 0; i < 7; i++) run_vec(i);

        // Abort at t=3 of a D=10 run, with a start pulsed (and inputs changed) while busy.
        repeat (4) sb_q.push_back(4'b1010);
        repeat (6) sb_q.push_back(4'b0000);
        start_pulse(10, 5, 3, 1, 1);
        step_check("abort_c0", o);
        @(negedge clk);
        step_check("abort_c1", o);
        start = 1'b1; delay = 8'd0; width1 = 8'd1;
        @(negedge clk);
        start = 1'b0;
        step_check("abort_c2", o);
        @(negedge clk);
        step_check("abort_c3", o);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int c = 4; c < 10; c++) begin
            if (c > 4) @(negedge clk);
            step_check($sformatf("abort_c%0d", c), o);
        end
        run_vec(0);

        // Abort and start in the same idle cycle: abort wins.
        repeat (4) sb_q.push_back(4'b0000);
        @(negedge clk);
        delay = 8'd2; width1 = 8'd2; width2 = 8'd2; gap = 8'd1; reps = 4'd1;
        start = 1'b1; abort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            step_check($sformatf("abort_start_c%0d", c), o);
        end

        // Reset dropped between edges mid-RUN clears outputs immediately; no done on release.
        repeat (3) sb_q.push_back(4'b1010);
        start_pulse(5, 5, 5, 1, 1);
        step_check("arst_c0", o);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            step_check($sformatf("arst_c%0d", c), o);
        end
        #2 reset = 1'b0;
        #1 chk("arst_immediate", {28'd0, signal1, signal2, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) sb_q.push_back(4'b0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            step_check($sformatf("arst_post_c%0d", c), o);
        end

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
